mem_port_arbiter: RTL and testbench

Sequences the CPU's single memory bus between the instruction-fetch (IF) requester and the data-access (MEM) requester. It accepts one transaction at a time and drives a req/ready/rvalid bus handshake. It returns a one-cycle done pulse with read data to the owning requester. It produces the `if_stall` and `mem_stall` signals consumed by pipeline traffic control. IF redirects (flushes) can cancel an in-flight fetch, whose response is then silently discarded.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and data access,
// one transaction at a time, with a starvation guard for fetch and flush-drop of fetches.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_done,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stall,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_ready,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t                r_state;
    logic                  r_mem;
    logic                  r_we;
    logic                  r_drop;
    logic [SW-1:0]         r_starve;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_mem_rdata;
    logic                  w_if_want;
    logic                  w_mem_win;
    logic                  w_drop;
    assign w_if_want = if_req && !if_flush;
    assign w_mem_win = mem_req && !(w_if_want && r_starve == SW'(STARVE_LIMIT));
    // a flush arriving in the completion cycle itself must also discard the fetch
    assign w_drop    = r_drop || (if_flush && !r_mem);
    assign bus_req   = r_state == ISSUE;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_wstrb = r_wstrb;
    assign if_done   = r_state == DONE && !r_mem;
    assign mem_done  = r_state == DONE && r_mem;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign if_stall  = if_req && !if_done;
    assign mem_stall = mem_req && !mem_done;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_mem       <= 1'b0;
            r_we        <= 1'b0;
            r_drop      <= 1'b0;
            r_starve    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_win) begin
                        r_mem    <= 1'b1;
                        r_we     <= mem_we;
                        r_addr   <= mem_addr;
                        r_wdata  <= mem_wdata;
                        r_wstrb  <= mem_wstrb;
                        r_starve <= w_if_want ? r_starve + 1'b1 : '0;
                        r_state  <= ISSUE;
                    end else if (w_if_want) begin
                        r_mem    <= 1'b0;
                        r_we     <= 1'b0;
                        r_addr   <= if_addr;
                        r_wdata  <= '0;
                        r_wstrb  <= '0;
                        r_starve <= '0;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_drop <= w_drop;
                    if (bus_ready) r_state <= r_we ? DONE : WAIT;
                end
                WAIT: begin
                    r_drop <= w_drop;
                    if (bus_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= w_drop ? IDLE : DONE;
                        if (!w_drop && r_mem) r_mem_rdata <= bus_rdata;
                        if (!w_drop && !r_mem) r_if_rdata <= bus_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations, plus a
// transaction-level model compared against the DUT on every cycle.
module tb_mem_port_arbiter;
    localparam int LIM = 4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [63:0] if_addr = '0;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [63:0] mem_addr = '0, mem_wdata = '0;
    logic [7:0]  mem_wstrb = '0;
    logic        t_ready = 1'b0, t_rvalid = 1'b0, auto_resp = 1'b0, resp_v = 1'b0;
    logic [63:0] bus_rdata = '0;
    logic        bus_ready, bus_rvalid;
    logic        if_done, if_stall, mem_done, mem_stall, bus_req, bus_we;
    logic [63:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [7:0]  bus_wstrb;
    int          errors = 0, checks = 0, cyc = 0, t0 = 1 << 30;
    logic [63:0] h_breq, h_ifd, h_memd, h_ifst, h_we;
    logic [63:0] h_addr [64];
    logic [63:0] h_wd [64];
    logic [63:0] h_ws [64];
    logic [63:0] h_ifrd [64];
    logic [63:0] h_memrd [64];
    logic        acc0 = 1'b0, acc1 = 1'b0;

    assign bus_ready  = auto_resp | t_ready;
    assign bus_rvalid = auto_resp ? resp_v : t_rvalid;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // auto responder: always ready, read data returns two cycles after acceptance
    initial forever begin
        @(negedge clk);
        acc0 = bus_req && bus_ready && !bus_we;
        @(posedge clk);
        #1;
        resp_v = acc1;
        acc1 = acc0;
    end

    // transaction-level model: one pending transaction, its bus phase and a pending done pulse
    logic        m_busy, m_acc, m_mem, m_we, m_drop, m_pulse, m_pmem, e_breq, e_ifd, e_memd, want_if, fin;
    logic [63:0] m_addr, m_wdata, m_if_rd, m_mem_rd;
    logic [7:0]  m_wstrb;
    int          m_starve, k;

    task automatic m_reset();
        m_busy = 0; m_acc = 0; m_mem = 0; m_we = 0; m_drop = 0; m_pulse = 0; m_pmem = 0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_if_rd = '0; m_mem_rd = '0; m_starve = 0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) m_reset();
            e_breq = m_busy && !m_acc;
            e_ifd  = m_pulse && !m_pmem;
            e_memd = m_pulse && m_pmem;
            chk("bus_req", 64'(bus_req), 64'(e_breq));
            chk("if_done", 64'(if_done), 64'(e_ifd));
            chk("mem_done", 64'(mem_done), 64'(e_memd));
            chk("if_stall", 64'(if_stall), 64'(if_req && !e_ifd));
            chk("mem_stall", 64'(mem_stall), 64'(mem_req && !e_memd));
            chk("if_rdata", if_rdata, m_if_rd);
            chk("mem_rdata", mem_rdata, m_mem_rd);
            if (e_breq) begin
                chk("bus_we", 64'(bus_we), 64'(m_we));
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_wdata", bus_wdata, m_wdata);
                chk("bus_wstrb", 64'(bus_wstrb), 64'(m_wstrb));
            end
            k = cyc - t0;
            if (k >= 0 && k < 64) begin
                h_breq[k] = bus_req; h_ifd[k] = if_done; h_memd[k] = mem_done;
                h_ifst[k] = if_stall; h_we[k] = bus_we; h_addr[k] = bus_addr;
                h_wd[k] = bus_wdata; h_ws[k] = 64'(bus_wstrb);
                h_ifrd[k] = if_rdata; h_memrd[k] = mem_rdata;
            end
            if (reset_n) begin
                if (m_pulse) m_pulse = 0;
                else if (m_busy) begin
                    if (!m_mem && if_flush) m_drop = 1;
                    fin = 0;
                    if (!m_acc) begin
                        if (bus_ready && m_we) fin = 1;
                        else if (bus_ready) m_acc = 1;
                    end else if (bus_rvalid) begin
                        fin = 1;
                        if (!m_drop && m_mem) m_mem_rd = bus_rdata;
                        if (!m_drop && !m_mem) m_if_rd = bus_rdata;
                    end
                    if (fin) begin
                        m_busy = 0; m_acc = 0; m_pulse = !m_drop; m_pmem = m_mem; m_drop = 0;
                    end
                end else begin
                    want_if = if_req && !if_flush;
                    if (mem_req && !(want_if && m_starve == LIM)) begin
                        m_busy = 1; m_mem = 1; m_we = mem_we; m_addr = mem_addr;
                        m_wdata = mem_wdata; m_wstrb = mem_wstrb;
                        m_starve = want_if ? (m_starve < LIM ? m_starve + 1 : LIM) : 0;
                    end else if (want_if) begin
                        m_busy = 1; m_mem = 0; m_we = 0; m_addr = if_addr;
                        m_wdata = '0; m_wstrb = '0; m_starve = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        go(2);
        chk("rst bus_req", 64'(bus_req), 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst done", 64'({if_done, mem_done}), 0);
        chk("rst if_rdata", if_rdata, 0);
        reset_n = 1'b1;
        go(2);
        // IF read
        t0 = cyc; if_req = 1; if_addr = 64'h1000;
        go(1); t_ready = 1;
        go(1); t_ready = 0;
        go(1); t_rvalid = 1; bus_rdata = 64'hDEADBEEF;
        go(1); t_rvalid = 0;
        go(1); if_req = 0;
        go(3);
        chk("ifrd bus_req c0-4", 64'(h_breq[4:0]), 64'b00010);
        chk("ifrd bus_addr c1", h_addr[1], 64'h1000);
        chk("ifrd bus_we c1", h_we[1], 0);
        chk("ifrd if_done c0-4", 64'(h_ifd[4:0]), 64'b10000);
        chk("ifrd if_rdata c4", h_ifrd[4], 64'hDEADBEEF);
        chk("ifrd if_stall c0-4", 64'(h_ifst[4:0]), 64'b01111);
        // simultaneous requests
        auto_resp = 1; bus_rdata = 64'hA5A5;
        t0 = cyc; if_req = 1; if_addr = 64'h1000; mem_req = 1; mem_we = 0; mem_addr = 64'h8000;
        go(5); mem_req = 0;
        go(5); if_req = 0;
        go(3);
        chk("sim bus_req c0-9", 64'(h_breq[9:0]), 64'b0001000010);
        chk("sim first addr", h_addr[1], 64'h8000);
        chk("sim second addr", h_addr[6], 64'h1000);
        chk("sim mem_done c0-9", 64'(h_memd[9:0]), 64'b0000010000);
        chk("sim if_done c0-9", 64'(h_ifd[9:0]), 64'b1000000000);
        chk("sim mem_rdata c4", h_memrd[4], 64'hA5A5);
        // starvation guard
        t0 = cyc; mem_req = 1; mem_we = 0; mem_addr = 64'h8000; if_req = 1; if_addr = 64'h1000;
        go(50); mem_req = 0; if_req = 0;
        go(4); auto_resp = 0;
        for (int g = 0; g < 10; g++) begin
            chk("starve bus_req", 64'(h_breq[5*g+1]), 1);
            chk("starve grant addr", h_addr[5*g+1], (g == 4 || g == 9) ? 64'h1000 : 64'h8000);
        end
        chk("starve if_done", 64'(h_ifd[49:0]), (64'd1 << 24) | (64'd1 << 49));
        go(2);
        // write with delayed ready and a stray rvalid
        t0 = cyc; mem_req = 1; mem_we = 1; mem_addr = 64'h40;
        mem_wdata = 64'h1122334455667788; mem_wstrb = 8'h0F;
        go(2); t_rvalid = 1;
        go(1); t_rvalid = 0;
        go(1); t_ready = 1;
        go(1); t_ready = 0;
        go(1); mem_req = 0; mem_we = 0;
        go(3);
        chk("wr bus_req c0-6", 64'(h_breq[6:0]), 64'b0011110);
        for (int c = 1; c <= 4; c++) begin
            chk("wr bus_addr", h_addr[c], 64'h40);
            chk("wr bus_we", h_we[c], 1);
            chk("wr bus_wdata", h_wd[c], 64'h1122334455667788);
            chk("wr bus_wstrb", h_ws[c], 64'h0F);
        end
        chk("wr mem_done c0-6", 64'(h_memd[6:0]), 64'b0100000);
        // flush during WAIT
        t0 = cyc; if_req = 1; if_addr = 64'h1000;
        go(1); t_ready = 1;
        go(1); t_ready = 0;
        go(1); if_flush = 1; if_req = 0;
        go(1); if_flush = 0;
        go(1); t_rvalid = 1; bus_rdata = 64'hBAD;
        go(1); t_rvalid = 0; if_req = 1; if_addr = 64'h2000;
        go(1); t_ready = 1;
        go(1); t_ready = 0;
        go(1); t_rvalid = 1; bus_rdata = 64'h2222;
        go(1); t_rvalid = 0;
        go(1); if_req = 0;
        go(3);
        chk("fl if_done c0-10", 64'(h_ifd[10:0]), 64'b10000000000);
        chk("fl if_rdata kept c6", h_ifrd[6], 64'hA5A5);
        chk("fl if_rdata kept c9", h_ifrd[9], 64'hA5A5);
        chk("fl reissue bus_req c7", 64'(h_breq[7]), 1);
        chk("fl reissue addr c7", h_addr[7], 64'h2000);
        chk("fl new if_rdata c10", h_ifrd[10], 64'h2222);
        // reset during WAIT
        t0 = cyc; mem_req = 1; mem_we = 0; mem_addr = 64'h100;
        go(1); t_ready = 1;
        go(1); t_ready = 0;
        go(1); reset_n = 0; mem_req = 0;
        #1;
        chk("rstw bus_req", 64'(bus_req), 0);
        chk("rstw bus_addr", bus_addr, 0);
        chk("rstw bus_we/wstrb", 64'({bus_we, bus_wstrb}), 0);
        chk("rstw bus_wdata", bus_wdata, 0);
        chk("rstw done", 64'({if_done, mem_done}), 0);
        chk("rstw if_rdata", if_rdata, 0);
        chk("rstw mem_rdata", mem_rdata, 0);
        go(2); reset_n = 1;
        go(1); t_rvalid = 1; bus_rdata = 64'h77;
        go(1); t_rvalid = 0;
        go(3);
        chk("rstw stray done c6-9", 64'({h_ifd[9:6], h_memd[9:6]}), 0);
        chk("rstw stray bus_req c6-9", 64'(h_breq[9:6]), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
